// File: rtl/matrix_stream_tx_if.sv
// Valid/ready word stream carrying one matrix element (or checksum word)
// per transfer together with its row/column position and frame marker.
interface matrix_stream_tx_if #(
  parameter int unsigned length = 8
);
  logic [length-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [3:0]        out_row;
  logic [3:0]        out_col;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last,
    output out_row,
    output out_col
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last,
    input  out_row,
    input  out_col
  );
endinterface

// File: rtl/matrix_stream_tx.sv
// matrix_stream_tx: captures a packed size x size matrix on a load strobe
// and streams its elements in row-major order over a valid/ready interface.
// Optional trailing checksum word enabled by macro MATRIX_TX_CHECKSUM_EN.
module matrix_stream_tx #(
  parameter int unsigned size   = 2,
  parameter int unsigned length = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [size*size*length-1:0]   matrix,
  output logic                          busy,
  output logic                          done,
  matrix_stream_tx_if.master            tx
);

  localparam int unsigned NUM  = size * size;
  localparam int unsigned LAST = NUM - 1;
  localparam int unsigned IW   = 8;

`ifdef MATRIX_TX_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
`endif

  state_t                      state_q, state_d;
  logic [size*size*length-1:0] snap_q, snap_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [3:0]                  row_q, row_d;
  logic [3:0]                  col_q, col_d;
  logic                        done_q, done_d;
`ifdef MATRIX_TX_CHECKSUM_EN
  logic [length-1:0]           csum_q, csum_d;
`endif

  logic [length-1:0] elem;
  logic              valid;
  logic              xfer;
  logic              at_last;

  // Element selector: compare-and-select mux over the snapshot, no multiplier on idx
  always_comb begin
    elem = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (idx_q == IW'(k)) begin
        elem = snap_q[k*length +: length];
      end
    end
  end

  assign valid   = (state_q != IDLE);
  assign xfer    = valid && tx.out_ready;
  assign at_last = (idx_q == IW'(LAST));

  // Stream outputs derived from the registered state
  always_comb begin
    tx.out_valid = valid;
    tx.out_data  = '0;
    tx.out_last  = 1'b0;
    tx.out_row   = row_q;
    tx.out_col   = col_q;
    case (state_q)
      SEND: begin
        tx.out_data = elem;
`ifndef MATRIX_TX_CHECKSUM_EN
        tx.out_last = at_last;
`endif
      end
`ifdef MATRIX_TX_CHECKSUM_EN
      CSUM: begin
        tx.out_data = csum_q;
        tx.out_last = 1'b1;
      end
`endif
      default: begin
        tx.out_data = '0;
      end
    endcase
  end

  assign busy = valid;
  assign done = done_q;

  // Next-state logic: capture, index/row/col advance, checksum accumulation
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
`ifdef MATRIX_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          snap_d  = matrix;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
`ifdef MATRIX_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
`ifdef MATRIX_TX_CHECKSUM_EN
          csum_d = csum_q + elem;
`endif
          if (at_last) begin
            // Row/col return to 0 here so a checksum word reports (0,0)
            idx_d = '0;
            row_d = '0;
            col_d = '0;
`ifdef MATRIX_TX_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 8'd1;
            if (col_q == 4'(size - 1)) begin
              col_d = '0;
              row_d = row_q + 4'd1;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
        end
      end
`ifdef MATRIX_TX_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
`ifdef MATRIX_TX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
`ifdef MATRIX_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Testbench for matrix_stream_tx: size=2 and size=1 instances, directed and
// randomized frames checked against a row-major reference word list.
module tb_matrix_stream_tx;

  logic clk = 1'b0;
  logic rst;

  logic        load_a;
  logic [31:0] matrix_a;
  logic        busy_a, done_a;
  logic        load_b;
  logic [7:0]  matrix_b;
  logic        busy_b, done_b;

  matrix_stream_tx_if #(.length(8)) bus_a ();
  matrix_stream_tx_if #(.length(8)) bus_b ();

  matrix_stream_tx #(.size(2), .length(8)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .load   (load_a),
    .matrix (matrix_a),
    .busy   (busy_a),
    .done   (done_a),
    .tx     (bus_a)
  );

  matrix_stream_tx #(.size(1), .length(8)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .load   (load_b),
    .matrix (matrix_b),
    .busy   (busy_b),
    .done   (done_b),
    .tx     (bus_b)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] r;
    logic [3:0] c;
    logic       l;
  } word_t;

  word_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference frame for a 2x2 matrix of bytes: row-major elements, optional sum word
  task automatic build_frame(input logic [31:0] m);
    logic [31:0] sum;
    logic [31:0] mv;
    word_t w;
    sum = 0;
    mv  = m;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      w.d = mv[8*k +: 8];
      w.r = 4'(k / 2);
      w.c = 4'(k % 2);
`ifdef MATRIX_TX_CHECKSUM_EN
      w.l = 1'b0;
`else
      w.l = (k == 3);
`endif
      sum = sum + {24'd0, w.d};
      exp_q.push_back(w);
    end
`ifdef MATRIX_TX_CHECKSUM_EN
    w.d = sum[7:0];
    w.r = 4'd0;
    w.c = 4'd0;
    w.l = 1'b1;
    exp_q.push_back(w);
`endif
  endtask

  // mode 0: always ready; 1: 3-cycle stall on element 1; 2: random ready + loads while busy
  task automatic run_frame_a(input logic [31:0] m, input int mode);
    word_t w;
    logic  r;
    int    stalls;
    int    np;
    int    guard;
    stalls = 0;
    np     = 0;
    guard  = 0;
    load_a   = 1'b1;
    matrix_a = m;
    @(negedge clk);
    load_a   = 1'b0;
    matrix_a = $urandom;
    build_frame(m);
    chk("busy_after_load", busy_a, 1);
    while (exp_q.size() > 0 && guard < 100) begin
      guard++;
      w = exp_q[0];
      chk("valid", bus_a.out_valid, 1);
      chk("data",  bus_a.out_data,  w.d);
      chk("row",   bus_a.out_row,   w.r);
      chk("col",   bus_a.out_col,   w.c);
      chk("last",  bus_a.out_last,  w.l);
      chk("done_mid", done_a, 0);
      case (mode)
        0: r = 1'b1;
        1: begin
          if (np == 1 && stalls < 3) begin
            r = 1'b0;
            stalls++;
          end else begin
            r = 1'b1;
          end
        end
        default: begin
          r = ($urandom_range(0, 99) < 60);
          load_a   = ($urandom_range(0, 2) == 0);
          matrix_a = 32'hFFFFFFFF;
        end
      endcase
      bus_a.out_ready = r;
      @(negedge clk);
      load_a = 1'b0;
      if (r) begin
        void'(exp_q.pop_front());
        np++;
      end
    end
    chk("frame_words_left", exp_q.size(), 0);
    chk("end_done",  done_a, 1);
    chk("end_valid", bus_a.out_valid, 0);
    chk("end_busy",  busy_a, 0);
    chk("end_last",  bus_a.out_last, 0);
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", done_a, 0);
    chk("no_second_frame", busy_a, 0);
  endtask

  initial begin
    rst             = 1'b1;
    load_a          = 1'b0;
    matrix_a        = '0;
    load_b          = 1'b0;
    matrix_b        = '0;
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",  busy_a, 0);
    chk("rst_valid", bus_a.out_valid, 0);
    chk("rst_last",  bus_a.out_last, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_data",  bus_a.out_data, 0);
    chk("rst_row",   bus_a.out_row, 0);
    chk("rst_col",   bus_a.out_col, 0);
    chk("rst_b_valid", bus_b.out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_load", busy_a, 0);

    // Basic frame, backpressure, load-while-busy, all-FF wraparound
    run_frame_a(32'h04030201, 0);
    run_frame_a(32'h04030201, 1);
    run_frame_a(32'h04030201, 2);
    run_frame_a(32'hFFFFFFFF, 0);

    // Asynchronous reset while element 03 is presented
    bus_a.out_ready = 1'b1;
    load_a   = 1'b1;
    matrix_a = 32'h04030201;
    @(negedge clk);
    load_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_data", bus_a.out_data, 8'h03);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus_a.out_valid, 0);
    chk("arst_busy",  busy_a, 0);
    chk("arst_last",  bus_a.out_last, 0);
    chk("arst_data",  bus_a.out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame_a(32'h04030201, 0);

    // Randomized frames with random backpressure
    for (int i = 0; i < 8; i++) begin
      run_frame_a($urandom, 2);
    end

    // Degenerate size=1 instance
    bus_b.out_ready = 1'b1;
    load_b   = 1'b1;
    matrix_b = 8'h5A;
    @(negedge clk);
    load_b   = 1'b0;
    matrix_b = 8'h00;
    chk("b_valid", bus_b.out_valid, 1);
    chk("b_data",  bus_b.out_data, 8'h5A);
    chk("b_row",   bus_b.out_row, 0);
    chk("b_col",   bus_b.out_col, 0);
`ifdef MATRIX_TX_CHECKSUM_EN
    chk("b_last_elem", bus_b.out_last, 0);
    @(negedge clk);
    chk("b_csum", bus_b.out_data, 8'h5A);
    chk("b_csum_last", bus_b.out_last, 1);
`else
    chk("b_last", bus_b.out_last, 1);
`endif
    @(negedge clk);
    chk("b_done",  done_b, 1);
    chk("b_valid_end", bus_b.out_valid, 0);
    chk("b_busy_end",  busy_b, 0);
    @(negedge clk);
    chk("b_done_pulse", done_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/matrix_stream_tx.md
# matrix_stream_tx

Serializing transmitter for the packed matrix bus used by the matrix add, subtract and transpose datapath. On a load strobe it captures one flattened size×size matrix and streams its elements out one per handshake, in row-major order, over a valid/ready interface. It sits after the combinational matrix operator and drives narrow downstream consumers such as a UART bridge, a display driver or a FIFO.

## Interface
Parameters:
- size, 2: matrix dimension N (1..15); N·N elements.
- length, 8: element width in bits.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- load  in  1  capture request; sampled only in IDLE.
- matrix  in  size·size·length  packed matrix. Element k = row·size+col occupies bits [length·(k+1)-1 : length·k].
- busy  out  1  high whenever state ≠ IDLE.
- out_data  out  length  current element, or the checksum word.
- out_valid  out  1  out_data is presented.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks the final word of a frame.
- out_row  out  4  row of the current element.
- out_col  out  4  column of the current element.
- done  out  1  one-cycle pulse after the final word transfers.

## Operation
- States: IDLE, SEND, and CSUM (CSUM exists only with the macro).
- IDLE:
  - load=1 registers matrix into an internal snapshot, clears the index to 0, and moves to SEND.
  - load=0 keeps the block in IDLE.
- SEND:
  - out_valid=1 and out_data = snapshot element[index].
  - out_row/out_col equal index / size and index % size, kept as counters (no divider).
- Transfer: a word transfers on any rising edge where out_valid && out_ready.
  - The transfer advances index, with col wrapping to 0 and row incrementing.
- The snapshot decouples the block from its input. Changes on `matrix` after capture do not affect the frame.
- Leaving SEND, on transfer of element size·size-1:
  - without the macro: go to IDLE and pulse done.
  - with the macro: go to CSUM.
- load while busy=1 is ignored, with no queueing.
- Backpressure: while out_valid && !out_ready, out_data, out_row, out_col and out_last hold stable.
- out_valid never drops mid-frame.
- size=1: the frame is a single element, with out_last on it when the macro is off.

## Timing
- Reset values: busy=0, out_valid=0, out_last=0, done=0, out_data=0, out_row=0, out_col=0, state=IDLE, snapshot=0.
- Reset mid-frame aborts immediately, and all outputs take their reset values asynchronously.
- Load latency:
  - load is sampled high at edge T.
  - busy and out_valid go high after T, with element 0 valid in cycle T+1.
- Throughput: one word per cycle while out_ready=1. With out_ready held high, a frame takes N·N cycles, or N·N+1 with the checksum.
- End of frame:
  - The final transfer happens at edge F.
  - After F: out_valid=0, busy=0, done=1 for exactly one cycle.
  - The earliest accepted new load is at edge F+1, so there is at least one idle cycle between frames.
- out_last is high only while the final word is presented.

## Configuration
- Macro `MATRIX_TX_CHECKSUM_EN`.
- Defined:
  - A checksum word follows the last element: the sum of all N·N elements mod 2^length, accumulated as elements transfer.
  - The word is presented in CSUM with out_row=0 and out_col=0.
  - out_last is asserted on the checksum word only.
- Undefined:
  - No CSUM state and no accumulator.
  - out_last is asserted on element N·N-1.

## Test plan
- Basic frame: size=2, length=8, matrix=32'h04030201, 1-cycle load pulse, out_ready=1.
  - Required: out_data 01,02,03,04 on consecutive cycles from T+1.
  - Required: row/col (0,0),(0,1),(1,0),(1,1).
  - Required: last on 04 (or checksum 0A with the macro), then done pulse and busy=0.
- Backpressure: same frame with out_ready low for 3 cycles while 02 is presented.
  - Required: 02 and (0,1) held stable.
  - Required: no word skipped or duplicated; total of 4 or 5 transfers.
- Load while busy: pulse load with matrix=32'hFFFFFFFF during the frame.
  - Required: the frame still carries 01..04, and no second frame starts.
- Async reset: assert rst while element 03 is presented.
  - Required: out_valid, busy and out_last are 0 immediately.
  - Required: a subsequent load restarts from element 01.
- Checksum wraparound (macro on): size=2, all elements FF.
  - Required: checksum word FC, with out_last=1.
- Degenerate size: size=1, matrix=8'h5A.
  - Required: a single word 5A with out_last=1 (macro off), and done at T+2.
